// File: rtl/mx_sysctl_if.sv
// CPU-side bus bundle for mx_sysctl: address, write data, write strobe and
// the MMU decode strobes that select the page, palette and FDD ports.
interface mx_sysctl_if;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        wr_n;
  logic        page_sel;
  logic        pal_sel;
  logic        fdd2_sel;

  modport master (
    output addr, din, wr_n, page_sel, pal_sel, fdd2_sel
  );

  modport slave (
    input addr, din, wr_n, page_sel, pal_sel, fdd2_sel
  );
endinterface

// File: rtl/mx_sysctl.sv
// mx_sysctl: Specialist MX system-control registers (RAM-disk page,
// palette latch, FDD drive/side port and CPU hold handshake).
// Optional feature macro: MX_HOLD_TIMEOUT_EN adds a hold timeout counter
// and the sticky hold_timeout flag; without it hold_timeout is tied low.
module mx_sysctl #(
  parameter int                 PAGE_BITS    = 4,
  parameter int                 NUM_RAMDISK  = 4,
  parameter int                 DRIVE_BITS   = 1,
  parameter logic [7:0]         PAL_RESET    = 8'hF0,
  parameter int                 TO_BITS      = 20,
  parameter logic [TO_BITS-1:0] HOLD_TIMEOUT = 20'd960000
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  mx,
  input  logic                  mxd,
  input  logic                  rks_load,
  mx_sysctl_if.slave            bus,
  input  logic                  fdd_drq,
  input  logic                  fdd_busy,
  output logic [PAGE_BITS-1:0]  page,
  output logic                  romp,
  output logic                  page_fault,
  output logic [7:0]            color_mx,
  output logic                  fdd_side,
  output logic [DRIVE_BITS-1:0] fdd_drive,
  output logic                  cpu_hold,
  output logic                  hold_timeout
);

  localparam logic [3:0]           NRD      = 4'(NUM_RAMDISK);
  localparam logic [PAGE_BITS-1:0] PAGE_RAM = '0;
  localparam logic [PAGE_BITS-1:0] PAGE_ROM = PAGE_BITS'(1);
  localparam logic [PAGE_BITS-1:0] PAGE_RD0 = PAGE_BITS'(2);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state, state_nxt;
  logic                   old_wr_n;
  logic                   wr_fall;
  logic                   fdd2_we, fdd2_we_q, fdd2_rise;
  logic                   hold_req, hold_rel, to_hit;
  logic [PAGE_BITS-1:0]   page_nxt;
  logic                   fault_nxt;
  logic                   unused_addr;

  // Only A15 and the low two address bits are decoded here.
  assign unused_addr = ^bus.addr[14:2];

  assign wr_fall   = old_wr_n & ~bus.wr_n;
  assign fdd2_we   = ~bus.wr_n & bus.fdd2_sel;
  assign fdd2_rise = fdd2_we & ~fdd2_we_q;
  assign hold_req  = fdd2_rise & (bus.addr[1:0] == 2'd0);
  assign hold_rel  = fdd_drq | ~fdd_busy;

  // Next page / fault value: tape load, then A15 auto-zero, then CPU write.
  always_comb begin
    page_nxt  = page;
    fault_nxt = page_fault;
    if (rks_load) begin
      page_nxt = PAGE_RAM;
    end else if (!(mx && mxd) && bus.addr[15]) begin
      page_nxt = PAGE_RAM;
    end else if (wr_fall && bus.page_sel && mxd) begin
      case (bus.addr[1:0])
        2'b00: page_nxt = PAGE_RAM;
        2'b01: begin
          if ({1'b0, bus.din[2:0]} < NRD) begin
            page_nxt  = PAGE_RD0 + PAGE_BITS'(bus.din[2:0]);
            fault_nxt = 1'b0;
          end else begin
            fault_nxt = 1'b1;
          end
        end
        default: page_nxt = PAGE_ROM;
      endcase
    end
  end

  // Page register, ROM decode and the write-strobe edge history.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      page       <= PAGE_ROM;
      romp       <= 1'b1;
      page_fault <= 1'b0;
      old_wr_n   <= 1'b1;
      fdd2_we_q  <= 1'b0;
    end else begin
      page       <= page_nxt;
      romp       <= (page_nxt == PAGE_ROM);
      page_fault <= fault_nxt;
      old_wr_n   <= bus.wr_n;
      fdd2_we_q  <= fdd2_we;
    end
  end

  // Palette latch, restored to its default while a tape image loads.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      color_mx <= PAL_RESET;
    end else if (rks_load) begin
      color_mx <= PAL_RESET;
    end else if (wr_fall && bus.pal_sel) begin
      color_mx <= bus.din;
    end
  end

  // FDD side and drive select, one update per fdd2 write strobe.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      fdd_side  <= 1'b0;
      fdd_drive <= '0;
    end else if (fdd2_rise) begin
      case (bus.addr[1:0])
        2'd2:    fdd_side  <= bus.din[0];
        2'd3:    fdd_drive <= bus.din[DRIVE_BITS-1:0];
        default: ;
      endcase
    end
  end

  // Hold FSM state register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Hold FSM transitions; a release always beats a request or a timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (hold_req && !hold_rel) state_nxt = HOLD;
      HOLD: begin
        if (hold_rel)      state_nxt = IDLE;
        else if (hold_req) state_nxt = HOLD;
        else if (to_hit)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold FSM output decode.
  always_comb begin
    cpu_hold = (state == HOLD);
  end

`ifdef MX_HOLD_TIMEOUT_EN
  localparam logic [TO_BITS-1:0] TO_LAST = HOLD_TIMEOUT - TO_BITS'(1);

  logic [TO_BITS-1:0] to_cnt;

  function automatic logic [TO_BITS-1:0] sat_inc(input logic [TO_BITS-1:0] v);
    sat_inc = (&v) ? v : v + TO_BITS'(1);
  endfunction

  assign to_hit = (to_cnt == TO_LAST);

  // Hold duration counter and sticky timeout flag; a new request restarts both.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      to_cnt       <= '0;
      hold_timeout <= 1'b0;
    end else if (hold_req) begin
      to_cnt       <= '0;
      hold_timeout <= 1'b0;
    end else if (state == HOLD) begin
      to_cnt <= sat_inc(to_cnt);
      if (!hold_rel && to_hit) hold_timeout <= 1'b1;
    end
  end
`else
  assign to_hit       = 1'b0;
  assign hold_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mx_sysctl.sv
// Directed bench for mx_sysctl (page register, palette, FDD port, hold FSM).
`timescale 1ns/1ps
module tb_mx_sysctl;

  logic       clk_sys = 1'b0;
  logic       reset_n, mx, mxd, rks_load, fdd_drq, fdd_busy;
  logic [3:0] page;
  logic       romp, page_fault, fdd_side, cpu_hold, hold_timeout;
  logic [7:0] color_mx;
  logic [0:0] fdd_drive;
  int         checks = 0;
  int         errors = 0;
  int         hi;

  mx_sysctl_if bus();

  always #5 clk_sys = ~clk_sys;

  mx_sysctl #(
    .PAGE_BITS(4), .NUM_RAMDISK(4), .DRIVE_BITS(1), .PAL_RESET(8'hF0),
    .TO_BITS(20), .HOLD_TIMEOUT(20'd16)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .mx(mx), .mxd(mxd),
    .rks_load(rks_load), .bus(bus), .fdd_drq(fdd_drq), .fdd_busy(fdd_busy),
    .page(page), .romp(romp), .page_fault(page_fault), .color_mx(color_mx),
    .fdd_side(fdd_side), .fdd_drive(fdd_drive), .cpu_hold(cpu_hold),
    .hold_timeout(hold_timeout)
  );

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_idle;
    bus.wr_n = 1'b1; bus.page_sel = 1'b0; bus.pal_sel = 1'b0; bus.fdd2_sel = 1'b0;
  endtask

  task automatic page_wr(input logic [15:0] a, input logic [7:0] d);
    bus.addr = a; bus.din = d; bus.page_sel = 1'b1; bus.wr_n = 1'b0;
    tick();
  endtask

  task automatic fdd_wr(input logic [15:0] a, input logic [7:0] d);
    bus.addr = a; bus.din = d; bus.fdd2_sel = 1'b1; bus.wr_n = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    mx = 0; mxd = 0; rks_load = 0; fdd_drq = 0; fdd_busy = 0;
    bus.addr = 16'h0000; bus.din = 8'h00; bus_idle();
    reset_n = 0; tick(); tick();
    checks++; if (page !== 4'd1) begin errors++; $display("FAIL rst_page got %h exp 1", page); end
    checks++; if (romp !== 1'b1) begin errors++; $display("FAIL rst_romp got %b exp 1", romp); end
    checks++; if (color_mx !== 8'hF0) begin errors++; $display("FAIL rst_color got %h exp f0", color_mx); end
    checks++; if ({cpu_hold, page_fault, hold_timeout, fdd_side, fdd_drive} !== 5'b0) begin
      errors++; $display("FAIL rst_flags got %b exp 00000", {cpu_hold, page_fault, hold_timeout, fdd_side, fdd_drive});
    end
    reset_n = 1; tick();
  endtask

  task automatic test_page;
    mx = 1; mxd = 1;
    page_wr(16'hFFFD, 8'h03);
    checks++; if (page !== 4'd5 || romp !== 1'b0 || page_fault !== 1'b0) begin
      errors++; $display("FAIL pg_rd3 got %h/%b/%b exp 5/0/0", page, romp, page_fault);
    end
    bus_idle(); tick();
    page_wr(16'hFFFD, 8'h07);
    checks++; if (page !== 4'd5 || page_fault !== 1'b1) begin
      errors++; $display("FAIL pg_oor got %h/%b exp 5/1", page, page_fault);
    end
    bus_idle(); tick();
    page_wr(16'hFFFC, 8'h00);
    checks++; if (page !== 4'd0 || page_fault !== 1'b1) begin
      errors++; $display("FAIL pg_ram got %h/%b exp 0/1", page, page_fault);
    end
    bus_idle(); tick();
    page_wr(16'hFFFD, 8'h04);
    checks++; if (page !== 4'd0 || page_fault !== 1'b1) begin
      errors++; $display("FAIL pg_edge4 got %h/%b exp 0/1", page, page_fault);
    end
    bus_idle(); tick();
    page_wr(16'hFFFD, 8'h00);
    checks++; if (page !== 4'd2 || page_fault !== 1'b0) begin
      errors++; $display("FAIL pg_rd0 got %h/%b exp 2/0", page, page_fault);
    end
    bus_idle(); tick();
    page_wr(16'hFFFE, 8'h00);
    checks++; if (page !== 4'd1 || romp !== 1'b1) begin
      errors++; $display("FAIL pg_rom got %h/%b exp 1/1", page, romp);
    end
    bus_idle(); tick();
  endtask

  task automatic test_a15;
    bus.addr = 16'h0000; mxd = 0; tick();
    checks++; if (page !== 4'd1) begin errors++; $display("FAIL a15_low got %h exp 1", page); end
    bus.addr = 16'h8000; tick();
    checks++; if (page !== 4'd0 || romp !== 1'b0) begin
      errors++; $display("FAIL a15_zero got %h/%b exp 0/0", page, romp);
    end
    mxd = 1; page_wr(16'hFFFE, 8'h00); bus_idle();
    bus.addr = 16'h8000; tick(); tick();
    checks++; if (page !== 4'd1) begin errors++; $display("FAIL a15_mxd got %h exp 1", page); end
    mx = 0; page_wr(16'hFFFD, 8'h01);
    checks++; if (page !== 4'd0) begin errors++; $display("FAIL a15_over got %h exp 0", page); end
    bus_idle(); mx = 1; bus.addr = 16'h0000; tick();
  endtask

  task automatic test_palette;
    page_wr(16'hFFFD, 8'h03); bus_idle(); tick();
    bus.addr = 16'h0000; bus.din = 8'h5A; bus.pal_sel = 1'b1; bus.wr_n = 1'b0; tick();
    checks++; if (color_mx !== 8'h5A) begin errors++; $display("FAIL pal_wr got %h exp 5a", color_mx); end
    bus.din = 8'h33; repeat (9) tick();
    checks++; if (color_mx !== 8'h5A) begin errors++; $display("FAIL pal_once got %h exp 5a", color_mx); end
    bus_idle(); tick();
    rks_load = 1; tick(); rks_load = 0;
    checks++; if (color_mx !== 8'hF0 || page !== 4'd0) begin
      errors++; $display("FAIL rks got %h/%h exp f0/0", color_mx, page);
    end
    tick();
  endtask

  task automatic test_hold;
    fdd_busy = 1; fdd_drq = 0;
    fdd_wr(16'hFFF0, 8'h00);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL hold_on got %b exp 1", cpu_hold); end
    bus_idle(); repeat (8) tick();
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL hold_keep got %b exp 1", cpu_hold); end
    fdd_drq = 1; tick();
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL hold_drq got %b exp 0", cpu_hold); end
    fdd_drq = 0; fdd_busy = 0;
    fdd_wr(16'hFFF0, 8'h00);
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL hold_nobusy got %b exp 0", cpu_hold); end
    bus_idle(); tick();
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL hold_nobusy2 got %b exp 0", cpu_hold); end
  endtask

  task automatic test_timeout;
    fdd_busy = 1;
    fdd_wr(16'hFFF0, 8'h00); bus_idle();
`ifdef MX_HOLD_TIMEOUT_EN
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (!cpu_hold) break;
      hi++; tick();
    end
    checks++; if (hi != 16) begin errors++; $display("FAIL to_len got %0d exp 16", hi); end
    checks++; if (hold_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", hold_timeout); end
    tick();
    fdd_wr(16'hFFF0, 8'h00); bus_idle();
    checks++; if (cpu_hold !== 1'b1 || hold_timeout !== 1'b0) begin
      errors++; $display("FAIL to_clear got %b/%b exp 1/0", cpu_hold, hold_timeout);
    end
`else
    repeat (40) tick();
    checks++; if (cpu_hold !== 1'b1 || hold_timeout !== 1'b0) begin
      errors++; $display("FAIL noto_hold got %b/%b exp 1/0", cpu_hold, hold_timeout);
    end
`endif
    fdd_busy = 0; tick();
    checks++; if (cpu_hold !== 1'b0 || hold_timeout !== 1'b0) begin
      errors++; $display("FAIL to_rel got %b/%b exp 0/0", cpu_hold, hold_timeout);
    end
  endtask

  task automatic test_side_drive;
    fdd_wr(16'hFFF2, 8'h01);
    checks++; if (fdd_side !== 1'b1) begin errors++; $display("FAIL side got %b exp 1", fdd_side); end
    bus.din = 8'h00; repeat (3) tick();
    checks++; if (fdd_side !== 1'b1) begin errors++; $display("FAIL side_once got %b exp 1", fdd_side); end
    bus_idle(); tick();
    fdd_wr(16'hFFF3, 8'h01); bus_idle(); tick();
    checks++; if (fdd_drive !== 1'b1) begin errors++; $display("FAIL drive got %b exp 1", fdd_drive); end
    fdd_wr(16'hFFF1, 8'hFE); bus_idle(); tick();
    checks++; if (fdd_side !== 1'b1 || fdd_drive !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL fdd_ign got %b/%b/%b exp 1/1/0", fdd_side, fdd_drive, cpu_hold);
    end
  endtask

  task automatic test_reset_mid_hold;
    fdd_busy = 1;
    fdd_wr(16'hFFF0, 8'h00); bus_idle();
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL mid_on got %b exp 1", cpu_hold); end
    reset_n = 0; tick();
    checks++; if (cpu_hold !== 1'b0 || page !== 4'd1 || fdd_side !== 1'b0 || fdd_drive !== 1'b0) begin
      errors++; $display("FAIL mid_rst got %b/%h/%b/%b exp 0/1/0/0", cpu_hold, page, fdd_side, fdd_drive);
    end
    reset_n = 1; fdd_busy = 0; tick();
  endtask

  initial begin
    test_reset();
    test_page();
    test_a15();
    test_palette();
    test_hold();
    test_timeout();
    test_side_drive();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
